// File: rtl/bit_counter_pkg.sv
// Shared types for the bit counter: controller state encoding, visible to the
// controller and to anything observing it.
package bit_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_counter_param_if.sv
// Request/result bundle of the bit counter: the requester drives start/mode/data
// and observes result/busy/done.
interface bit_counter_param_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data;
  logic [CW-1:0]    result;
  logic             busy;
  logic             done;

  modport master (output start, output mode, output data,
                  input  result, input busy, input done);
  modport slave  (input  start, input mode, input data,
                  output result, output busy, output done);
endinterface

// File: rtl/bit_counter_ctrl.sv
// IDLE/COUNT/DONE sequencer for the bit counter; busy and done are registered
// copies of the next state so they track the state register exactly.
module bit_counter_ctrl
  import bit_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic reg_zero,
  output logic load,
  output logic clear,
  output logic shift,
  output logic busy,
  output logic done
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)    state_d = ST_COUNT;
      ST_COUNT: if (reg_zero) state_d = ST_DONE;
      ST_DONE:  if (!start)   state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COUNT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The operand is captured only on start=0 idle cycles, so the value seen on
  // the last cycle before start rose is the one that gets counted.
  assign load  = (state_q == ST_IDLE) && !start;
  assign clear = (state_q == ST_IDLE) && !start;
  assign shift = (state_q == ST_COUNT) && !reg_zero;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: rtl/bit_counter_param.sv
// Counts ones (mode=0) or zeros (mode=1) of a WIDTH-bit operand by shifting it
// right until empty; result is valid while done is high.
module bit_counter_param
  import bit_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  bit_counter_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    result_q, result_d;
  logic             reg_zero;
  logic             load, clear, shift;

  // Counting zeros is counting ones of the inverted operand.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
      assign operand[gi] = bus.data[gi] ^ bus.mode;
    end
  endgenerate

  assign reg_zero = (shift_q == '0);

  bit_counter_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (bus.start),
    .reg_zero (reg_zero),
    .load     (load),
    .clear    (clear),
    .shift    (shift),
    .busy     (bus.busy),
    .done     (bus.done)
  );

  always_comb begin
    shift_d  = shift_q;
    result_d = result_q;
    if (clear) result_d = '0;
    if (load)  shift_d  = operand;
    // At most WIDTH increments happen per count, and CW holds WIDTH.
    if (shift) begin
      shift_d  = shift_q >> 1;
      result_d = result_q + {{(CW-1){1'b0}}, shift_q[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= '0;
      result_q <= '0;
    end else begin
      shift_q  <= shift_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_bit_counter_param.sv
// Directed bench for bit_counter_param at WIDTH=8 and WIDTH=16 with
// hand-computed cycle counts and results.
module tb_bit_counter_param;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bit_counter_param_if #(.WIDTH(8))  if8 ();
  bit_counter_param_if #(.WIDTH(16)) if16 ();

  bit_counter_param #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  bit_counter_param #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

  // One complete count on the 8-bit instance; leaves start high in DONE.
  task automatic run8(input string tag, input logic [7:0] d, input logic m,
                      input int exp_cyc, input int exp_res);
    int   n;
    logic both;
    logic [7:0] opnd;
    if8.start = 1'b0;
    if8.data  = d;
    if8.mode  = m;
    tick();
    check_val({tag, "_idle_res"}, 64'(if8.result), 64'd0);
    if8.start = 1'b1;
    tick();
    n    = 0;
    both = 1'b0;
    while (if8.busy && n < 200) begin
      if (if8.done) both = 1'b1;
      n++;
      tick();
    end
    opnd = m ? ~d : d;
    check_val({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check_val({tag, "_done"}, 64'(if8.done), 64'd1);
    check_val({tag, "_result"}, 64'(if8.result), 64'(exp_res));
    check_val({tag, "_popcnt"}, 64'(if8.result), 64'(popcount(64'(opnd))));
    check_val({tag, "_excl"}, 64'(both), 64'd0);
    $display("TXN %s data=%02h mode=%0d cycles=%0d result=%0d", tag, d, m, n, if8.result);
  endtask

  task automatic release8(input string tag);
    if8.start = 1'b0;
    tick();
    check_val({tag, "_rel_done"}, 64'(if8.done), 64'd0);
    check_val({tag, "_rel_busy"}, 64'(if8.busy), 64'd0);
  endtask

  initial begin
    int n;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    if8.start  = 1'b0;
    if8.mode   = 1'b0;
    if8.data   = '0;
    if16.start = 1'b0;
    if16.mode  = 1'b0;
    if16.data  = '0;
    tick();
    tick();
    check_val("rst_busy", 64'(if8.busy), 64'd0);
    check_val("rst_done", 64'(if8.done), 64'd0);
    check_val("rst_result", 64'(if8.result), 64'd0);
    check_val("rst16_result", 64'(if16.result), 64'd0);
    reset = 1'b0;

    run8("aa_ones", 8'hAA, 1'b0, 9, 4);
    release8("aa_ones");
    run8("aa_zeros", 8'hAA, 1'b1, 8, 4);
    release8("aa_zeros");
    run8("ff_ones", 8'hFF, 1'b0, 9, 8);
    release8("ff_ones");
    run8("00_ones", 8'h00, 1'b0, 1, 0);
    release8("00_ones");
    run8("00_zeros", 8'h00, 1'b1, 9, 8);

    // Start held after done: result must stay put with no recount.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("hold_done", 64'(if8.done), 64'd1);
      check_val("hold_result", 64'(if8.result), 64'd8);
    end
    release8("hold");

    // Operand change mid-count must not disturb the captured value 0x01.
    if8.start = 1'b0;
    if8.data  = 8'h01;
    if8.mode  = 1'b0;
    tick();
    if8.start = 1'b1;
    tick();
    check_val("chg_busy1", 64'(if8.busy), 64'd1);
    if8.data = 8'hFF;
    if8.mode = 1'b1;
    n = 1;
    tick();
    while (if8.busy && n < 200) begin
      n++;
      tick();
    end
    check_val("chg_cycles", 64'(n), 64'd2);
    check_val("chg_result", 64'(if8.result), 64'd1);
    $display("TXN chg data=01 mode=0 cycles=%0d result=%0d", n, if8.result);
    if8.data = 8'hFF;
    if8.mode = 1'b0;
    tick();
    check_val("chg_hold_result", 64'(if8.result), 64'd1);
    release8("chg");

    // Reset in the third COUNT cycle, with start still high.
    if8.start = 1'b0;
    if8.data  = 8'hAA;
    if8.mode  = 1'b0;
    tick();
    if8.start = 1'b1;
    tick();
    tick();
    tick();
    check_val("mid_busy", 64'(if8.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_busy", 64'(if8.busy), 64'd0);
    check_val("mid_rst_done", 64'(if8.done), 64'd0);
    check_val("mid_rst_result", 64'(if8.result), 64'd0);
    $display("TXN mid_reset data=aa busy=%0d done=%0d result=%0d", if8.busy, if8.done, if8.result);
    run8("rst_recover", 8'h0F, 1'b0, 5, 4);
    release8("rst_recover");

    // Wide instance: all-ones operand gives the full-width count.
    if16.data  = 16'hFFFF;
    if16.mode  = 1'b0;
    if16.start = 1'b0;
    tick();
    if16.start = 1'b1;
    tick();
    n = 0;
    while (if16.busy && n < 200) begin
      n++;
      tick();
    end
    check_val("w16_cycles", 64'(n), 64'd17);
    check_val("w16_done", 64'(if16.done), 64'd1);
    check_val("w16_result", 64'(if16.result), 64'd16);
    check_val("w16_popcnt", 64'(if16.result), 64'(popcount(64'(if16.data))));
    $display("TXN w16 data=ffff mode=0 cycles=%0d result=%0d", n, if16.result);
    if16.start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_counter_param.md
BIT_COUNTER_PARAM -- requirements
Module: bit_counter_param

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..64.
REQ-002 Derived constant CW = $clog2(WIDTH+1): result width, so that a result of WIDTH fits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 start  input  1  level request; high begins counting, must be dropped to re-arm.
REQ-006 mode  input  1  0 = count ones, 1 = count zeros; sampled together with data.
REQ-007 data  input  WIDTH  operand.
REQ-008 result  output  CW  bit count; valid while done=1.
REQ-009 busy  output  1  high while in COUNT.
REQ-010 done  output  1  high while in DONE.

Function
REQ-011 FSM states IDLE, COUNT, DONE; all outputs registered or decoded from state and registers only (Moore).
REQ-012 IDLE: each cycle with start=0, the shift register loads data if mode=0 or ~data if mode=1, and result clears to 0.
REQ-013 IDLE with start=1: transition to COUNT; no load that cycle, so the operand is the value captured on the last start=0 cycle.
REQ-014 COUNT: each cycle, if the shift register is nonzero, it shifts right one bit with 0 fill, and result increments when its bit 0 = 1.
REQ-015 COUNT with shift register = 0: transition to DONE; no shift, no increment.
REQ-016 Cycles spent in COUNT = (index of highest set bit of the loaded operand) + 2; a zero operand spends exactly 1 cycle.
REQ-017 DONE: result holds; stay while start=1; start=0 -> IDLE.
REQ-018 data and mode changes while in COUNT or DONE have no effect on result.
REQ-019 result never wraps: the maximum value is WIDTH, reached for an all-ones loaded operand.
REQ-020 start held continuously from IDLE through DONE produces exactly one count; a new count requires at least one start=0 cycle.
REQ-021 busy = (state==COUNT); done = (state==DONE); busy and done are never both high.

Reset
REQ-022 On reset=1 at a clock edge: state <= IDLE, result <= 0, shift register <= 0, from any state including mid-COUNT.
REQ-023 reset has priority over start; outputs are busy=0, done=0, result=0 in the cycle after reset.
REQ-024 With reset=0 and start=0, the first IDLE cycle after reset loads the operand normally.

Structure
REQ-025 The state enum (IDLE, COUNT, DONE) resides in package bit_counter_pkg, shared by the controller and the bench.
REQ-026 The controller is the sub-module bit_counter_ctrl, with inputs start and reg_zero and outputs load, clear, shift, busy and done.
REQ-027 The datapath (shift register, CW-bit result counter, inversion mux) lives in bit_counter_param and instantiates bit_counter_ctrl.
REQ-028 The design uses no latches; every next-state case assigns a default.

Verification (WIDTH=8 unless stated)
REQ-029 data=0xAA, mode=0, start 0->1 -> 9 COUNT cycles, then done=1 with result=4.
REQ-030 data=0xAA, mode=1 (operand 0x55) -> 8 COUNT cycles, then result=4; data=0xFF, mode=0 -> result=8.
REQ-031 data=0x00, mode=0 -> 1 COUNT cycle, result=0; data=0x00, mode=1 -> result=8 with no overflow.
REQ-032 data changed to 0xFF two cycles into COUNT of 0x01 -> result=1; start held high 10 cycles after done -> done stays 1 and no recount.
REQ-033 reset=1 asserted in the 3rd COUNT cycle -> next cycle IDLE, result=0, busy=0, done=0; the following start with 0x0F yields result=4.
REQ-034 WIDTH=16, data=0xFFFF, mode=0 -> result=16 (CW=5); the bench asserts result equals the popcount of the operand on every done.
